// File: rtl/conveyor_sort_sequencer.sv
// conveyor_sort_sequencer
// Sequences one conveyor sort lane. It runs the belt, times each detected item
// from the entry sensor to the piston, and fires and retracts the piston for
// rejected items. It also keeps saturating pass and reject counts. A critical
// fault latches a HALT that only an operator acknowledge clears.
module conveyor_sort_sequencer #(
    parameter int TRAVEL_CYC  = 8,
    parameter int PUSH_CYC    = 4,
    parameter int RETRACT_CYC = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             warn_i,
    input  logic             crit_i,
    input  logic             item_det_i,
    input  logic             item_rej_i,
    input  logic             ack_i,
    output logic             motor_o,
    output logic             piston_o,
    output logic             warn_o,
    output logic             emg_o,
    output logic             busy_o,
    output logic             overrun_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] rej_cnt_o
);

    // The timer only ever holds (phase length - 1), so it is sized for the longest phase.
    localparam int MAX_TP  = (TRAVEL_CYC > PUSH_CYC) ? TRAVEL_CYC : PUSH_CYC;
    localparam int MAX_CYC = (MAX_TP > RETRACT_CYC) ? MAX_TP : RETRACT_CYC;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] TRAVEL_LOAD  = TMR_W'(TRAVEL_CYC - 1);
    localparam logic [TMR_W-1:0] PUSH_LOAD    = TMR_W'(PUSH_CYC - 1);
    localparam logic [TMR_W-1:0] RETRACT_LOAD = TMR_W'(RETRACT_CYC - 1);

    typedef enum logic [2:0] {
        ST_STOP    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_TRAVEL  = 3'd2,
        ST_PUSH    = 3'd3,
        ST_RETRACT = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_rej;
    logic             r_motor;
    logic             r_piston;
    logic             r_warn;
    logic             r_emg;
    logic             r_busy;
    logic             r_overrun;

    state_t           w_state_next;
    logic [TMR_W-1:0] w_timer_next;
    logic             w_rej_next;
    logic             w_overrun_set;
    logic [1:0]       w_cnt_inc;     // [0] = pass, [1] = reject

    logic [CNT_W-1:0] r_cnt [2];

    // Next-state, timer and event decode; a critical fault overrides every item transition
    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_rej_next    = r_rej;
        w_overrun_set = 1'b0;
        w_cnt_inc     = 2'b00;

        case (r_state)
            ST_STOP: begin
                // A fault seen while stopped keeps the belt stopped but is not latched.
                if (!crit_i) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (crit_i) begin
                    w_state_next = ST_HALT;
                end else if (item_det_i) begin
                    w_state_next = ST_TRAVEL;
                    w_timer_next = TRAVEL_LOAD;
                    w_rej_next   = item_rej_i;
                end
            end

            ST_TRAVEL: begin
                w_overrun_set = item_det_i;
                if (crit_i) begin
                    w_state_next = ST_HALT;
                end else if (r_timer == '0) begin
                    if (r_rej) begin
                        w_state_next = ST_PUSH;
                        w_timer_next = PUSH_LOAD;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_cnt_inc[0] = 1'b1;
                    end
                end else begin
                    w_timer_next = r_timer - TMR_W'(1);
                end
            end

            ST_PUSH: begin
                w_overrun_set = item_det_i;
                if (crit_i) begin
                    w_state_next = ST_HALT;
                end else if (r_timer == '0) begin
                    w_state_next = ST_RETRACT;
                    w_timer_next = RETRACT_LOAD;
                end else begin
                    w_timer_next = r_timer - TMR_W'(1);
                end
            end

            ST_RETRACT: begin
                w_overrun_set = item_det_i;
                if (crit_i) begin
                    w_state_next = ST_HALT;
                end else if (r_timer == '0) begin
                    w_state_next = ST_IDLE;
                    w_cnt_inc[1] = 1'b1;
                end else begin
                    w_timer_next = r_timer - TMR_W'(1);
                end
            end

            ST_HALT: begin
                if (ack_i && !crit_i) begin
                    w_state_next = ST_STOP;
                end
            end

            default: begin
                w_state_next = ST_STOP;
            end
        endcase
    end

    // State register, with the outputs registered from the next state so they move on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_STOP;
            r_timer  <= '0;
            r_rej    <= 1'b0;
            r_motor  <= 1'b0;
            r_piston <= 1'b0;
            r_warn   <= 1'b0;
            r_emg    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_timer  <= w_timer_next;
            r_rej    <= w_rej_next;
            r_motor  <= (w_state_next == ST_IDLE)   || (w_state_next == ST_TRAVEL) ||
                        (w_state_next == ST_PUSH)   || (w_state_next == ST_RETRACT);
            r_piston <= (w_state_next == ST_PUSH);
            r_busy   <= (w_state_next == ST_TRAVEL) || (w_state_next == ST_PUSH) ||
                        (w_state_next == ST_RETRACT);
            r_emg    <= (w_state_next == ST_HALT);
            r_warn   <= warn_i || crit_i || (w_state_next == ST_HALT);
        end
    end

    // Sticky overrun flag: an item was dropped because another was still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end
    end

    // Pass and reject counters share one saturating structure
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            // Increment on completion, holding at all-ones rather than wrapping
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt[gi] <= '0;
                end else if (w_cnt_inc[gi] && (r_cnt[gi] != {CNT_W{1'b1}})) begin
                    r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign motor_o    = r_motor;
    assign piston_o   = r_piston;
    assign warn_o     = r_warn;
    assign emg_o      = r_emg;
    assign busy_o     = r_busy;
    assign overrun_o  = r_overrun;
    assign pass_cnt_o = r_cnt[0];
    assign rej_cnt_o  = r_cnt[1];

endmodule
